delay_tap_ctrl: RTL and testbench
=================================

Name: delay_tap_ctrl

Overview:
- Calibration and tracking controller for the 512-tap delay line.
- Drives the line's one-hot tap-enable bus from a registered tap index.
- After a start request it runs a 9-step successive-approximation (SAR) search using an external phase-detector bit, then tracks drift with filtered ±1 steps.
- Supports a manual tap override for characterisation.

Parameters:
- TAP_W, 9: tap index width; the enable bus is 2**TAP_W bits (512).
- SETTLE_CYC, 16: cycles per tap trial, covering line settling plus the detector window; minimum 2.
- FILT_N, 4: consecutive same-direction detector samples required for one track step; minimum 1.

Ports:
- clk, input, 1: controller clock.
- rst_n, input, 1: reset; asynchronous, active-low.
- start, input, 1: level-sampled in IDLE; begins SAR calibration.
- stop, input, 1: returns to IDLE from any state; current tap is held.
- phase_early, input, 1: synchronous detector result. 1 means the delayed edge is early, so more delay is needed.
- manual_en, input, 1: manual override.
- manual_tap, input, TAP_W: tap index used while manual_en=1.
- en, output, 2**TAP_W: one-hot tap enable to the delay line.
- tap, output, TAP_W: current tap index.
- busy, output, 1: high in SAR.
- locked, output, 1: high in TRACK.
- sat, output, 1: sticky; tracking tried to step past 0 or 2**TAP_W-1. Cleared on start.

Behaviour:
- Reset values: tap=0, en=1 (bit 0 only), busy=0, locked=0, sat=0, state IDLE, all counters 0.
- en is a registered decode of tap, updated on the same edge as tap. en is exactly one-hot in every cycle, including reset; it is never zero and never has two bits set.
- States: IDLE, SAR, TRACK.
- Priority per cycle: manual_en > stop > state logic.
- manual_en=1, any state:
  - Next state IDLE; tap <= manual_tap every cycle.
  - busy=0, locked=0; sat unchanged.
  - Settle and filter counters cleared.
- IDLE: tap holds. If start=1 (and manual_en=0, stop=0):
  - Next cycle enter SAR with tap={1,0...0} (256), bit pointer=TAP_W-1.
  - Settle counter=0, sat cleared.
- SAR:
  - Each trial lasts exactly SETTLE_CYC cycles. The settle counter counts 0..SETTLE_CYC-1, and phase_early is sampled only when the counter = SETTLE_CYC-1.
  - On that sample: phase_early=1 keeps the trial bit, 0 clears it.
  - If the pointer is >0, the next bit is set for the next trial. The tap update is a single registered write of the combined clear/keep and set.
  - After the bit-0 decision: next state TRACK, locked=1, busy=0.
  - Total SAR duration is TAP_W*SETTLE_CYC cycles. locked rises 1+TAP_W*SETTLE_CYC cycles after the start edge (145 with defaults).
  - Result is the largest tap for which phase_early=1 under a monotonic detector; 0 if none.
- TRACK:
  - One sample per SETTLE_CYC window, taken in the last cycle.
  - The filter counts consecutive samples of equal value; a value change restarts the count at 1.
  - When the count reaches FILT_N: tap += 1 if the value is 1, tap -= 1 if 0. The count then resets to 0.
  - Saturation: at tap=max with an up step, or tap=0 with a down step, tap holds and sat <= 1. No wrap-around.
  - locked stays 1 until stop or manual_en.
- start while in SAR or TRACK: ignored.
- stop: next state IDLE, busy=0, locked=0, tap holds.
- Reset asserted mid-operation: all state returns asynchronously to reset values.

Test Plan:
1. Reset, then release -> tap=0, en=0x…001 (only bit 0 set), busy=0, locked=0, sat=0. Check one-hot on every cycle of the run.
2. Detector model early=(tap<300), start pulse -> busy high for 144 cycles. Trial sequence: 256, 384, 320, 288, 304, 296, 300, 298, 299. Final tap=299, locked=1 at cycle 145.
3. Locked at 299, model changed to early=(tap<310) -> tap steps +1 every 4 windows (64 cycles), reaching 309 then dithering 309/310. sat stays 0.
4. Model early=1 always -> SAR gives 511. In TRACK, after 4 windows sat=1 and tap stays 511.
5. manual_en=1 with manual_tap=37 during SAR -> next cycle tap=37, en bit 37 only, busy=0, locked=0. Release -> IDLE, tap holds 37.
6. rst_n low for 1 cycle mid-SAR -> immediate tap=0, en bit 0, busy=0. Then start -> a full 144-cycle SAR reruns.

Source files
------------

// File: rtl/delay_tap_ctrl_if.sv
// rtl/delay_tap_ctrl_if.sv - control/status bundle between the delay-tap controller and its user
// The master side drives requests and the detector bit; the slave side (the controller) drives the tap outputs.
interface delay_tap_ctrl_if #(
    parameter int TAP_W = 9
);
    logic                  start;
    logic                  stop;
    logic                  phase_early;
    logic                  manual_en;
    logic [TAP_W-1:0]      manual_tap;
    logic [2**TAP_W-1:0]   en;
    logic [TAP_W-1:0]      tap;
    logic                  busy;
    logic                  locked;
    logic                  sat;

    modport master (
        output start, stop, phase_early, manual_en, manual_tap,
        input  en, tap, busy, locked, sat
    );

    modport slave (
        input  start, stop, phase_early, manual_en, manual_tap,
        output en, tap, busy, locked, sat
    );
endinterface

// File: rtl/delay_tap_ctrl.sv
// rtl/delay_tap_ctrl.sv - SAR calibration and filtered drift tracking for a one-hot tapped delay line
// en is decoded from the next tap value so it is registered on the same edge as tap and is always one-hot.
module delay_tap_ctrl #(
    parameter int TAP_W      = 9,
    parameter int SETTLE_CYC = 16,
    parameter int FILT_N     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    delay_tap_ctrl_if.slave  bus
);
    localparam int NTAP  = 2**TAP_W;
    localparam int PTR_W = (TAP_W > 1) ? $clog2(TAP_W) : 1;
    localparam int SET_W = $clog2(SETTLE_CYC);
    localparam int FLT_W = $clog2(FILT_N + 1);
    localparam logic [TAP_W-1:0] TAP_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_SAR, ST_TRACK} state_t;

    state_t             r_state;
    logic [TAP_W-1:0]   r_tap;
    logic [NTAP-1:0]    r_en;
    logic [PTR_W-1:0]   r_ptr;
    logic [SET_W-1:0]   r_settle;
    logic [FLT_W-1:0]   r_filt_cnt;
    logic               r_filt_val;
    logic               r_busy;
    logic               r_locked;
    logic               r_sat;

    logic               w_last;
    logic [TAP_W-1:0]   w_trial_bit;
    logic [TAP_W-1:0]   w_sar_tap;
    logic [FLT_W-1:0]   w_filt_cnt_nxt;
    logic               w_step;
    logic               w_at_bound;
    logic [TAP_W-1:0]   w_tap_nxt;

    always_comb begin
        w_last      = (r_settle == SET_W'(SETTLE_CYC - 1));
        w_trial_bit = TAP_W'(1) << r_ptr;
        // Resolve the current trial bit and arm the next one in a single write.
        w_sar_tap   = (bus.phase_early ? r_tap : (r_tap & ~w_trial_bit))
                    | ((r_ptr != '0) ? (w_trial_bit >> 1) : '0);

        if ((r_filt_cnt != '0) && (r_filt_val == bus.phase_early))
            w_filt_cnt_nxt = r_filt_cnt + FLT_W'(1);
        else
            w_filt_cnt_nxt = FLT_W'(1);
        w_step     = (w_filt_cnt_nxt == FLT_W'(FILT_N));
        w_at_bound = bus.phase_early ? (r_tap == TAP_MAX) : (r_tap == '0);

        w_tap_nxt = r_tap;
        if (bus.manual_en) begin
            w_tap_nxt = bus.manual_tap;
        end else if (!bus.stop) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start)
                        w_tap_nxt = TAP_W'(1) << (TAP_W - 1);
                end
                ST_SAR: begin
                    if (w_last)
                        w_tap_nxt = w_sar_tap;
                end
                ST_TRACK: begin
                    if (w_last && w_step && !w_at_bound)
                        w_tap_nxt = bus.phase_early ? (r_tap + TAP_W'(1)) : (r_tap - TAP_W'(1));
                end
                default: w_tap_nxt = r_tap;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tap      <= '0;
            r_en       <= NTAP'(1);
            r_ptr      <= '0;
            r_settle   <= '0;
            r_filt_cnt <= '0;
            r_filt_val <= 1'b0;
            r_busy     <= 1'b0;
            r_locked   <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_tap <= w_tap_nxt;
            r_en  <= NTAP'(1) << w_tap_nxt;

            if (bus.manual_en) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_locked   <= 1'b0;
                r_settle   <= '0;
                r_filt_cnt <= '0;
                r_filt_val <= 1'b0;
            end else if (bus.stop) begin
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_locked <= 1'b0;
                r_settle <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            r_state    <= ST_SAR;
                            r_ptr      <= PTR_W'(TAP_W - 1);
                            r_settle   <= '0;
                            r_filt_cnt <= '0;
                            r_filt_val <= 1'b0;
                            r_sat      <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                    ST_SAR: begin
                        r_settle <= w_last ? '0 : (r_settle + SET_W'(1));
                        if (w_last) begin
                            if (r_ptr == '0) begin
                                r_state  <= ST_TRACK;
                                r_busy   <= 1'b0;
                                r_locked <= 1'b1;
                            end else begin
                                r_ptr <= r_ptr - PTR_W'(1);
                            end
                        end
                    end
                    ST_TRACK: begin
                        r_settle <= w_last ? '0 : (r_settle + SET_W'(1));
                        if (w_last) begin
                            r_filt_val <= bus.phase_early;
                            if (w_step) begin
                                r_filt_cnt <= '0;
                                if (w_at_bound)
                                    r_sat <= 1'b1;
                            end else begin
                                r_filt_cnt <= w_filt_cnt_nxt;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.en     = r_en;
    assign bus.tap    = r_tap;
    assign bus.busy   = r_busy;
    assign bus.locked = r_locked;
    assign bus.sat    = r_sat;
endmodule

// File: tb/tb_delay_tap_ctrl.sv
// tb/tb_delay_tap_ctrl.sv - directed bench for delay_tap_ctrl with a threshold phase-detector model
module tb_delay_tap_ctrl;
    localparam int TAP_W = 9;
    localparam int NTAP  = 2**TAP_W;

    logic clk = 1'b0;
    logic rst_n;
    int   thresh;
    int   n_checks = 0;
    int   n_errors = 0;
    int   busy_cycles;

    delay_tap_ctrl_if #(.TAP_W(TAP_W)) ifc ();

    delay_tap_ctrl #(.TAP_W(TAP_W), .SETTLE_CYC(16), .FILT_N(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Monotonic detector: more delay is wanted while the tap is below the threshold.
    assign ifc.phase_early = (int'(ifc.tap) < thresh);

    task automatic check(input string tag, input logic [NTAP-1:0] obs, input logic [NTAP-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_tap(input string tag, input int t);
        check({tag, "_tap"}, NTAP'(ifc.tap), NTAP'(t));
        check({tag, "_en"}, ifc.en, NTAP'(1) << t);
        check({tag, "_busy"}, NTAP'(ifc.busy), NTAP'(0));
        check({tag, "_locked"}, NTAP'(ifc.locked), NTAP'(0));
    endtask

    // Runs a full SAR from a start sampled on the next edge; start level is left as given.
    task automatic run_sar(input string tag, input int final_tap, input bit chk_trials);
        int seq [9];
        seq = '{256, 384, 320, 288, 304, 296, 300, 298, 299};
        ifc.start = 1'b1;
        step();
        busy_cycles = ifc.busy ? 1 : 0;
        check({tag, "_t0"}, NTAP'(ifc.tap), NTAP'(256));
        for (int n = 2; n <= 145; n++) begin
            step();
            if (ifc.busy) busy_cycles++;
            check({tag, "_busy"}, NTAP'(ifc.busy), NTAP'(n < 145));
            check({tag, "_locked"}, NTAP'(ifc.locked), NTAP'(n == 145));
            if (chk_trials && ((n - 1) % 16 == 0) && n < 145)
                check({tag, "_trial"}, NTAP'(ifc.tap), NTAP'(seq[(n - 1) / 16]));
        end
        check({tag, "_busy_cycles"}, NTAP'(busy_cycles), NTAP'(144));
        check({tag, "_final"}, NTAP'(ifc.tap), NTAP'(final_tap));
        check({tag, "_final_en"}, ifc.en, NTAP'(1) << final_tap);
    endtask

    always @(negedge clk) begin
        check("en_onehot", NTAP'($onehot(ifc.en)), NTAP'(1));
    end

    initial begin
        int exp3 [12];
        exp3 = '{300, 301, 302, 303, 304, 305, 306, 307, 308, 309, 310, 309};

        rst_n = 1'b0;
        thresh = 300;
        ifc.start = 1'b0;
        ifc.stop = 1'b0;
        ifc.manual_en = 1'b0;
        ifc.manual_tap = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check_idle_tap("reset", 0);
        check("reset_sat", NTAP'(ifc.sat), NTAP'(0));

        run_sar("sar299", 299, 1'b1);
        ifc.start = 1'b0;
        check("sar299_sat", NTAP'(ifc.sat), NTAP'(0));

        thresh = 310;
        repeat (63) step();
        check("track_pre_step", NTAP'(ifc.tap), NTAP'(299));
        step();
        check("track_step1", NTAP'(ifc.tap), NTAP'(exp3[0]));
        for (int k = 1; k < 12; k++) begin
            repeat (64) step();
            check("track_step", NTAP'(ifc.tap), NTAP'(exp3[k]));
            check("track_locked", NTAP'(ifc.locked), NTAP'(1));
        end
        check("track_sat", NTAP'(ifc.sat), NTAP'(0));

        ifc.stop = 1'b1;
        step();
        ifc.stop = 1'b0;
        check_idle_tap("stop", 309);
        repeat (3) step();
        check("stop_hold", NTAP'(ifc.tap), NTAP'(309));

        thresh = 512;
        run_sar("sar511", 511, 1'b0);
        ifc.start = 1'b0;
        repeat (63) step();
        check("sat_before", NTAP'(ifc.sat), NTAP'(0));
        step();
        check("sat_set", NTAP'(ifc.sat), NTAP'(1));
        check("sat_tap", NTAP'(ifc.tap), NTAP'(511));
        repeat (64) step();
        check("sat_hold_tap", NTAP'(ifc.tap), NTAP'(511));
        check("sat_sticky", NTAP'(ifc.sat), NTAP'(1));

        thresh = 300;
        ifc.stop = 1'b1;
        step();
        ifc.stop = 1'b0;
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        check("start_clr_sat", NTAP'(ifc.sat), NTAP'(0));
        check("start_busy", NTAP'(ifc.busy), NTAP'(1));
        repeat (20) step();
        ifc.manual_en = 1'b1;
        ifc.manual_tap = 9'd37;
        step();
        check_idle_tap("manual", 37);
        ifc.manual_en = 1'b0;
        ifc.manual_tap = 9'd100;
        repeat (5) step();
        check_idle_tap("manual_release", 37);

        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        repeat (30) step();
        check("pre_rst_busy", NTAP'(ifc.busy), NTAP'(1));
        rst_n = 1'b0;
        #1;
        check_idle_tap("async_rst", 0);
        step();
        rst_n = 1'b1;
        step();
        check_idle_tap("post_rst", 0);

        // start stays high across the whole rerun; it must be ignored outside IDLE.
        run_sar("rerun", 299, 1'b1);
        repeat (10) step();
        check("rerun_hold", NTAP'(ifc.tap), NTAP'(299));
        check("rerun_locked", NTAP'(ifc.locked), NTAP'(1));
        ifc.start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
